// File: rtl/fetch_unit.sv
// fetch_unit: request/response instruction fetch with an in-order prefetch FIFO and redirect flush.
// Optional build macro FETCH_PERF_EN adds fetched/dropped/stall performance counters.
module fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_rdy,
    input  logic            i_imem_rvld,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic            o_insn_vld,
    output logic [XLEN-1:0] o_insn,
    output logic [XLEN-1:0] o_insn_pc,
    input  logic            i_insn_rdy,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_misalign
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     o_perf_fetched,
    output logic [31:0]     o_perf_dropped,
    output logic [31:0]     o_perf_stall
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    logic [XLEN-1:0] r_fetch_pc, r_head_pc;
    logic [XLEN-1:0] r_mem [FIFO_DEPTH];
    logic [CW-1:0]   r_count, r_out, r_drop;
    logic [AW-1:0]   r_rd, r_wr;
    logic            r_misalign;

    logic [CW:0]     w_used;
    logic [CW-1:0]   w_out_nxt;
    logic [XLEN-1:0] w_tgt;
    logic            w_req, w_hs, w_push, w_pop;

    // Credit covers words already queued plus words still in flight, so a response always has a slot.
    assign w_used      = {1'b0, r_count} + {1'b0, r_out};
    assign w_req       = !i_rst && !i_redirect && (w_used < DEPTH_C);
    assign w_hs        = w_req && i_imem_rdy;
    assign w_push      = i_imem_rvld && (r_drop == '0) && !i_redirect;
    assign w_pop       = o_insn_vld && i_insn_rdy && !i_redirect;
    assign w_out_nxt   = r_out + CW'(w_hs) - CW'(i_imem_rvld);
    assign w_tgt       = {i_redirect_pc[XLEN-1:2], 2'b00};

    assign o_imem_req  = w_req;
    assign o_imem_addr = r_fetch_pc;
    assign o_insn_vld  = (r_count != '0);
    assign o_insn      = o_insn_vld ? r_mem[r_rd] : '0;
    assign o_insn_pc   = r_head_pc;
    assign o_misalign  = r_misalign;

    // Control state: fetch/head PCs, FIFO pointers, in-flight and drop counters; redirect flushes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_pc <= RESET_PC;
            r_head_pc  <= RESET_PC;
            r_count    <= '0;
            r_out      <= '0;
            r_drop     <= '0;
            r_rd       <= '0;
            r_wr       <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_out      <= w_out_nxt;
            r_misalign <= i_redirect && (|i_redirect_pc[1:0]);
            if (i_redirect) begin
                r_fetch_pc <= w_tgt;
                r_head_pc  <= w_tgt;
                r_count    <= '0;
                r_rd       <= '0;
                r_wr       <= '0;
                r_drop     <= w_out_nxt;
            end else begin
                if (w_hs) r_fetch_pc <= r_fetch_pc + XLEN'(4);
                if (w_pop) begin
                    r_head_pc <= r_head_pc + XLEN'(4);
                    r_rd      <= r_rd + AW'(1);
                end
                if (w_push) r_wr <= r_wr + AW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
                if (i_imem_rvld && (r_drop != '0)) r_drop <= r_drop - CW'(1);
            end
        end
    end

    // FIFO storage; contents need no reset since validity lives in r_count.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= i_imem_rdata;
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_pf, r_pd, r_ps;

    assign o_perf_fetched = r_pf;
    assign o_perf_dropped = r_pd;
    assign o_perf_stall   = r_ps;

    // Saturating event counters for accepted words, discarded words and consumer stall cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pf <= '0;
            r_pd <= '0;
            r_ps <= '0;
        end else begin
            if (w_push && !(&r_pf)) r_pf <= r_pf + 32'd1;
            if (i_imem_rvld && !w_push && !(&r_pd)) r_pd <= r_pd + 32'd1;
            if (!o_insn_vld && i_insn_rdy && !(&r_ps)) r_ps <= r_ps + 32'd1;
        end
    end
`endif
endmodule
